pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable of the PC and IF/ID registers, the clear of IF/ID, and the bubble insertion into ID/EX.
- Detects load-use hazards and taken branches/jumps resolved in ID.
- Tracks the occupancy of the multi-cycle multiply/divide unit with a down-counter, so dependent HI/LO reads and back-to-back mul/div are held in ID.

## Interface
Parameters:
- MULDIV_LAT, 4, mul/div occupancy in cycles including issue cycle; legal range 2..15
- CNT_W, 4, width of occupancy counter; must hold MULDIV_LAT-1

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- ID_rs  in  5  rs field of instruction in ID
- ID_rt  in  5  rt field of instruction in ID
- ID_uses_rs  in  1  ID instruction reads rs
- ID_uses_rt  in  1  ID instruction reads rt
- ID_is_muldiv  in  1  ID instruction is mult/multu/div/divu
- ID_reads_hilo  in  1  ID instruction is mfhi/mflo
- ID_branch_taken  in  1  taken beq/bne/j/jal/jr resolved in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_dst  in  5  destination register of instruction in EX
- PC_write  out  1  PC register update enable
- IF_ID_write  out  1  IF/ID register update enable
- IF_ID_flush  out  1  IF/ID register loads 0 (nop) at next edge
- ID_EX_bubble  out  1  ID/EX register loads control-zero at next edge
- muldiv_issue  out  1  ID mul/div instruction advances this cycle
- muldiv_busy  out  1  mul/div unit occupied (state MD_BUSY)

## Operation
- **State machine:** RUN and MD_BUSY, with counter cnt[CNT_W-1:0].
- **Load-use hazard:** load_use = EX_MemRead & EX_dst!=0 & ((ID_uses_rs & ID_rs==EX_dst) | (ID_uses_rt & ID_rt==EX_dst)).
- **Mul/div hazard:** md_hold = muldiv_busy & (ID_is_muldiv | ID_reads_hilo).
- **Stall:** stall = load_use | md_hold. When stall is 1:
  - PC_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0, muldiv_issue=0.
- **Taken branch:** if ID_branch_taken and not stall, IF_ID_flush=1, PC_write=1, IF_ID_write=1, ID_EX_bubble=0.
  - Stall has priority: a branch whose operands are still in flight is never resolved.
- **Issue:** muldiv_issue = ID_is_muldiv & ~stall.
- **Transitions:**
  - RUN→MD_BUSY on muldiv_issue, loading cnt=MULDIV_LAT-1.
  - MD_BUSY: cnt decrements each cycle. On the cycle with cnt==1, the next state is RUN and cnt goes to 0.
  - A mul/div held in ID during the last busy cycle issues on the first RUN cycle.
- **Idle:** no hazard → PC_write=1, IF_ID_write=1, both flush/bubble 0.

## Timing
- Hazard outputs are combinational from inputs and state, valid before the rising edge of the cycle they govern.
- Only state and cnt are registered.
- **Load-use stall:** exactly 1 cycle. The load leaves EX, so the condition self-clears.
- **Mul/div occupancy:** muldiv_busy is high for exactly MULDIV_LAT-1 cycles after the issue cycle.
  - A dependent mfhi in ID immediately after issue stalls MULDIV_LAT-1 cycles.
- **Reset:** while reset is asserted, state=RUN and cnt=0 immediately. With all inputs low, outputs are:
  - PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, muldiv_issue=0, muldiv_busy=0.
- **Reset mid-busy:** busy aborts at once. No pending stall survives reset.
- **Simultaneous events:**
  - Load-use plus taken branch → stall only, no flush.
  - Load-use plus ID_is_muldiv → stall, no issue, state unchanged.
  - md_hold plus branch → stall.
- $0 is never a hazard destination.

## Configuration
- Macro: HAZARD_PERF_CNT_EN.
- **Defined:**
  - Adds output stall_cycles (32 bits). It increments on every clock with stall=1 and saturates at 32'hFFFF_FFFF.
  - Adds output flush_cycles (32 bits). It increments on every clock with IF_ID_flush=1.
  - Both reset to 0.
- **Undefined:** neither port nor the counters exist. All other behaviour is identical.

## Test plan
- **Reset:** reset pulse mid-cycle with MD_BUSY, cnt=2 → same instant state RUN, muldiv_busy=0, PC_write=1, IF_ID_write=1.
- **Load-use:** EX_MemRead=1, EX_dst=8, ID_rs=8, ID_uses_rs=1 → one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle, with EX_MemRead=0, all enables 1.
- **$0 destination:** EX_MemRead=1, EX_dst=0, ID_rt=0, ID_uses_rt=1 → no stall.
- **Taken branch:** ID_branch_taken=1, no hazard → IF_ID_flush=1 for 1 cycle, PC_write=1. Same with load-use present → IF_ID_flush=0, stall=1.
- **Mul/div occupancy (MULDIV_LAT=4):** mult issues at cycle 0, then mflo is held in ID.
  - muldiv_busy=1 for cycles 1-3 and mflo stalls in those cycles.
  - mflo advances at cycle 4.
  - A second mult in ID at cycle 3 issues at cycle 4 with muldiv_issue=1.
- **Perf counters (HAZARD_PERF_CNT_EN defined):** 3 load-use stalls plus 2 flushes → stall_cycles=3, flush_cycles=2. Reset clears both to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Raises load-use
// stalls, flushes IF/ID on taken branches/jumps resolved in ID, and holds
// mul/div and HI/LO readers in ID while the multi-cycle mul/div unit is busy.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_cycles performance counters.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,  // occupancy incl. issue cycle, 2..15
    parameter int CNT_W      = 4   // must hold MULDIV_LAT-1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rs,
    input  logic       ID_uses_rt,
    input  logic       ID_is_muldiv,
    input  logic       ID_reads_hilo,
    input  logic       ID_branch_taken,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_dst,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_bubble,
    output logic       muldiv_issue,
    output logic       muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic md_hold;
    logic stall;

    assign muldiv_busy = (state_q == MD_BUSY);

    // Hazard detection: a load in EX feeding ID, or a mul/div-unit conflict.
    always_comb begin
        load_use = EX_MemRead && (EX_dst != 5'd0) &&
                   ((ID_uses_rs && (ID_rs == EX_dst)) ||
                    (ID_uses_rt && (ID_rt == EX_dst)));
        md_hold  = muldiv_busy && (ID_is_muldiv || ID_reads_hilo);
        stall    = load_use || md_hold;
    end

    // Pipeline control outputs; a stall always wins over a taken branch.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        muldiv_issue = 1'b0;
        if (stall) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else begin
            IF_ID_flush  = ID_branch_taken;
            muldiv_issue = ID_is_muldiv;
        end
    end

    // Next state: issue loads the occupancy counter, busy counts it down to 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (muldiv_issue) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and occupancy counter registers; reset aborts any busy period.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Performance counters: stall count saturates, flush count wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (IF_ID_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MULDIV_LAT=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// later, well before the next rising edge.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_uses_rs;
    logic       ID_uses_rt;
    logic       ID_is_muldiv;
    logic       ID_reads_hilo;
    logic       ID_branch_taken;
    logic       EX_MemRead;
    logic [4:0] EX_dst;
    logic       PC_write;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ID_EX_bubble;
    logic       muldiv_issue;
    logic       muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .MULDIV_LAT(4),
        .CNT_W     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_uses_rs     (ID_uses_rs),
        .ID_uses_rt     (ID_uses_rt),
        .ID_is_muldiv   (ID_is_muldiv),
        .ID_reads_hilo  (ID_reads_hilo),
        .ID_branch_taken(ID_branch_taken),
        .EX_MemRead     (EX_MemRead),
        .EX_dst         (EX_dst),
        .PC_write       (PC_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_bubble   (ID_EX_bubble),
        .muldiv_issue   (muldiv_issue),
        .muldiv_busy    (muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the five pipeline control outputs plus busy in one go.
    task automatic check_ctl(input string tag, input logic pcw, input logic ifw,
                             input logic fl, input logic bub, input logic iss,
                             input logic busy);
        check({tag, ".PC_write"},     {31'd0, PC_write},     {31'd0, pcw});
        check({tag, ".IF_ID_write"},  {31'd0, IF_ID_write},  {31'd0, ifw});
        check({tag, ".IF_ID_flush"},  {31'd0, IF_ID_flush},  {31'd0, fl});
        check({tag, ".ID_EX_bubble"}, {31'd0, ID_EX_bubble}, {31'd0, bub});
        check({tag, ".muldiv_issue"}, {31'd0, muldiv_issue}, {31'd0, iss});
        check({tag, ".muldiv_busy"},  {31'd0, muldiv_busy},  {31'd0, busy});
    endtask

    task automatic idle_inputs();
        ID_rs           = 5'd0;
        ID_rt           = 5'd0;
        ID_uses_rs      = 1'b0;
        ID_uses_rt      = 1'b0;
        ID_is_muldiv    = 1'b0;
        ID_reads_hilo   = 1'b0;
        ID_branch_taken = 1'b0;
        EX_MemRead      = 1'b0;
        EX_dst          = 5'd0;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        // Reset state with all inputs low.
        check_ctl("reset", 1, 1, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;

        // Load-use on rs: one stall cycle, then the load has left EX.
        EX_MemRead = 1'b1; EX_dst = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
        #1 check_ctl("lu_rs", 0, 0, 0, 1, 0, 0);
        next_cycle();
        EX_MemRead = 1'b0;
        #1 check_ctl("lu_clear", 1, 1, 0, 0, 0, 0);
        next_cycle();

        // Load-use on rt.
        idle_inputs();
        EX_MemRead = 1'b1; EX_dst = 5'd5; ID_rt = 5'd5; ID_uses_rt = 1'b1;
        #1 check_ctl("lu_rt", 0, 0, 0, 1, 0, 0);
        // Matching rt that the instruction does not read is no hazard.
        ID_uses_rt = 1'b0;
        #1 check_ctl("lu_rt_unused", 1, 1, 0, 0, 0, 0);
        // Non-matching register is no hazard.
        ID_uses_rt = 1'b1; ID_rt = 5'd6;
        #1 check_ctl("lu_rt_nomatch", 1, 1, 0, 0, 0, 0);
        next_cycle();

        // $0 is never a hazard destination.
        idle_inputs();
        EX_MemRead = 1'b1; EX_dst = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b1;
        #1 check_ctl("zero_dst", 1, 1, 0, 0, 0, 0);
        next_cycle();

        // Taken branch without hazard flushes IF/ID.
        idle_inputs();
        ID_branch_taken = 1'b1;
        #1 check_ctl("branch", 1, 1, 1, 0, 0, 0);
        // Taken branch with load-use: stall only.
        EX_MemRead = 1'b1; EX_dst = 5'd9; ID_rs = 5'd9; ID_uses_rs = 1'b1;
        #1 check_ctl("branch_lu", 0, 0, 0, 1, 0, 0);
        next_cycle();

        // Load-use with mul/div in ID: no issue, state stays RUN.
        idle_inputs();
        EX_MemRead = 1'b1; EX_dst = 5'd3; ID_rs = 5'd3; ID_uses_rs = 1'b1;
        ID_is_muldiv = 1'b1;
        #1 check_ctl("lu_muldiv", 0, 0, 0, 1, 0, 0);
        next_cycle();
        idle_inputs();
        #1 check_ctl("lu_muldiv_after", 1, 1, 0, 0, 0, 0);

        // mult issues at cycle 0, mflo held in ID during cycles 1-3.
        ID_is_muldiv = 1'b1;
        #1 check_ctl("md_c0_issue", 1, 1, 0, 0, 1, 0);
        next_cycle();
        ID_is_muldiv = 1'b0; ID_reads_hilo = 1'b1;
        #1 check_ctl("md_c1_hold", 0, 0, 0, 1, 0, 1);
        next_cycle();
        // md_hold plus branch: still a stall, no flush.
        ID_branch_taken = 1'b1;
        #1 check_ctl("md_c2_hold_br", 0, 0, 0, 1, 0, 1);
        next_cycle();
        ID_branch_taken = 1'b0;
        #1 check_ctl("md_c3_hold", 0, 0, 0, 1, 0, 1);
        next_cycle();
        #1 check_ctl("md_c4_advance", 1, 1, 0, 0, 0, 0);
        next_cycle();

        // Second sequence: idle while busy is no stall, then a held mult
        // issues on the first RUN cycle.
        idle_inputs();
        ID_is_muldiv = 1'b1;
        #1 check_ctl("md2_c0_issue", 1, 1, 0, 0, 1, 0);
        next_cycle();
        idle_inputs();
        #1 check_ctl("md2_c1_idle", 1, 1, 0, 0, 0, 1);
        next_cycle();
        #1 check_ctl("md2_c2_idle", 1, 1, 0, 0, 0, 1);
        next_cycle();
        ID_is_muldiv = 1'b1;
        #1 check_ctl("md2_c3_held", 0, 0, 0, 1, 0, 1);
        next_cycle();
        #1 check_ctl("md2_c4_issue", 1, 1, 0, 0, 1, 0);
        next_cycle();
        // cycle 5: cnt=3, cycle 6: cnt=2.
        ID_is_muldiv = 1'b0; ID_reads_hilo = 1'b1;
        #1 check_ctl("md2_c5_busy", 0, 0, 0, 1, 0, 1);
        next_cycle();
        #1 check_ctl("md2_c6_busy", 0, 0, 0, 1, 0, 1);

        // Asynchronous reset mid-cycle with cnt=2 aborts busy at once.
        #1 reset = 1'b1;
        #1 check_ctl("reset_mid_busy", 1, 1, 0, 0, 0, 0);
        #1 reset = 1'b0;
        next_cycle();
        #1 check_ctl("after_reset", 1, 1, 0, 0, 0, 0);
        idle_inputs();

`ifdef HAZARD_PERF_CNT_EN
        // Perf counters: clear, then 3 load-use stalls and 2 flushes.
        next_cycle();
        reset = 1'b1;
        #1 check("perf_rst_stall", stall_cycles, 32'd0);
        check("perf_rst_flush", flush_cycles, 32'd0);
        reset = 1'b0;
        next_cycle();
        EX_MemRead = 1'b1; EX_dst = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        idle_inputs();
        ID_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) next_cycle();
        idle_inputs();
        next_cycle();
        check("perf_stall", stall_cycles, 32'd3);
        check("perf_flush", flush_cycles, 32'd2);
        reset = 1'b1;
        #1 check("perf_clr_stall", stall_cycles, 32'd0);
        check("perf_clr_flush", flush_cycles, 32'd0);
        reset = 1'b0;
`endif

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
